// File: rtl/sshooter_ssg_mix.sv
// SSG three-channel mixer: snapshots the channel levels and gains once per sample period,
// forms a signed gain-weighted sum over three MAC cycles, and registers a saturated 16-bit sample.
module sshooter_ssg_mix #(
    parameter int DIV   = 256,
    parameter int SHIFT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         ch_a,
    input  logic [7:0]         ch_b,
    input  logic [7:0]         ch_c,
    input  logic [7:0]         gain_a,
    input  logic [7:0]         gain_b,
    input  logic [7:0]         gain_c,
    input  logic               mute,
    output logic signed [15:0] out,
    output logic               sample
);

    localparam logic [9:0] DIV_M1 = 10'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC_A = 3'd1,
        S_MAC_B = 3'd2,
        S_MAC_C = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             r_state;
    logic [9:0]         r_div;
    logic [7:0]         r_ch_a, r_ch_b, r_ch_c;
    logic [7:0]         r_gain_a, r_gain_b, r_gain_c;
    logic               r_mute;
    logic signed [18:0] r_acc;
    logic signed [15:0] r_out;
    logic               r_sample;

    logic               w_tick;
    logic [7:0]         w_sel_ch;
    logic [7:0]         w_sel_gain;
    logic signed [8:0]  w_diff;
    logic signed [8:0]  w_gain9;
    logic signed [16:0] w_prod;
    logic signed [18:0] w_prod_ext;
    logic signed [22:0] w_shift;
    logic signed [15:0] w_sat;

    assign w_tick = (r_div == 10'd0);

    // Sample-period divider: free-running down-counter reloading at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= DIV_M1;
        end else if (w_tick) begin
            r_div <= DIV_M1;
        end else begin
            r_div <= r_div - 10'd1;
        end
    end

    // Operand select: one shared multiplier serves the three MAC states.
    always_comb begin
        w_sel_ch   = r_ch_c;
        w_sel_gain = r_gain_c;
        case (r_state)
            S_MAC_A: begin
                w_sel_ch   = r_ch_a;
                w_sel_gain = r_gain_a;
            end
            S_MAC_B: begin
                w_sel_ch   = r_ch_b;
                w_sel_gain = r_gain_b;
            end
            default: begin
                w_sel_ch   = r_ch_c;
                w_sel_gain = r_gain_c;
            end
        endcase
    end

    // Level is offset-binary around 128; both operands are 9-bit signed so the product fits 17 bits.
    assign w_diff     = $signed({1'b0, w_sel_ch}) - 9'sd128;
    assign w_gain9    = $signed({1'b0, w_sel_gain});
    assign w_prod     = w_diff * w_gain9;
    assign w_prod_ext = {{2{w_prod[16]}}, w_prod};
    assign w_shift    = {{4{r_acc[18]}}, r_acc} <<< SHIFT;

    // Saturate the scaled sum to the signed 16-bit output range.
    always_comb begin
        if (w_shift > 23'sd32767) begin
            w_sat = 16'sh7FFF;
        end else if (w_shift < -23'sd32768) begin
            w_sat = 16'sh8000;
        end else begin
            w_sat = w_shift[15:0];
        end
    end

    // Sequencer: snapshot on tick, three MAC cycles, then register the sample and pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ch_a   <= 8'd0;
            r_ch_b   <= 8'd0;
            r_ch_c   <= 8'd0;
            r_gain_a <= 8'd0;
            r_gain_b <= 8'd0;
            r_gain_c <= 8'd0;
            r_mute   <= 1'b0;
            r_acc    <= 19'sd0;
            r_out    <= 16'sd0;
            r_sample <= 1'b0;
        end else begin
            r_sample <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_ch_a   <= ch_a;
                        r_ch_b   <= ch_b;
                        r_ch_c   <= ch_c;
                        r_gain_a <= gain_a;
                        r_gain_b <= gain_b;
                        r_gain_c <= gain_c;
                        r_mute   <= mute;
                        r_acc    <= 19'sd0;
                        r_state  <= S_MAC_A;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_MAC_A: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_MAC_B;
                end
                S_MAC_B: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_MAC_C;
                end
                S_MAC_C: begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_out    <= r_mute ? 16'sd0 : w_sat;
                    r_sample <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out    = r_out;
    assign sample = r_sample;

endmodule

// File: tb/tb_sshooter_ssg_mix.sv
// Self-checking bench for sshooter_ssg_mix: directed corner cases plus randomized inputs
// compared every cycle against an arithmetic reference of the mixer's sample schedule.
module tb_sshooter_ssg_mix;

    localparam int DIV   = 256;
    localparam int SHIFT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [7:0]         ch_a = 8'd128, ch_b = 8'd128, ch_c = 8'd128;
    logic [7:0]         gain_a = 8'd64, gain_b = 8'd64, gain_c = 8'd64;
    logic               mute = 1'b0;
    logic signed [15:0] out;
    logic               sample;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int edge_k    = 0;
    int exp_out   = 0;
    int exp_pulse = 0;
    int due_q[$];
    int val_q[$];

    sshooter_ssg_mix #(.DIV(DIV), .SHIFT(SHIFT)) dut (
        .clk    (clk),
        .reset  (reset),
        .ch_a   (ch_a),
        .ch_b   (ch_b),
        .ch_c   (ch_c),
        .gain_a (gain_a),
        .gain_b (gain_b),
        .gain_c (gain_c),
        .mute   (mute),
        .out    (out),
        .sample (sample)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mix(input int ca, input int cb, input int cc,
                               input int ga, input int gb, input int gc, input bit m);
        int acc;
        int v;
        acc = (ca - 128) * ga + (cb - 128) * gb + (cc - 128) * gc;
        v   = acc * (1 << SHIFT);
        if (m) return 0;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: inputs are captured every DIV edges after release; the result appears 4 edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_k    = 0;
            exp_out   = 0;
            exp_pulse = 0;
            due_q.delete();
            val_q.delete();
        end else begin
            edge_k++;
            exp_pulse = 0;
            if (due_q.size() > 0 && due_q[0] == edge_k) begin
                exp_out   = val_q[0];
                exp_pulse = 1;
                void'(due_q.pop_front());
                void'(val_q.pop_front());
            end
            if (edge_k % DIV == 0) begin
                due_q.push_back(edge_k + 4);
                val_q.push_back(mix(int'(ch_a), int'(ch_b), int'(ch_c),
                                    int'(gain_a), int'(gain_b), int'(gain_c), mute));
            end
        end
    end

    // Continuous comparison of both outputs against the reference, away from the active edge.
    always @(negedge clk) begin
        check_val("sample", int'(sample), exp_pulse);
        check_val("out", int'(out), exp_out);
    end

    task automatic wait_pulse(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample && n < 2 * DIV + 8);
        check_val({tag, "_pulse"}, int'(sample), 1);
    endtask

    task automatic wait_phase(input int m);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(edge_k >= DIV && edge_k % DIV == m) && n < 2 * DIV + 8);
        check_val("phase", edge_k % DIV, m);
    endtask

    task automatic set_in(input int ca, input int cb, input int cc,
                          input int ga, input int gb, input int gc);
        ch_a   = 8'(ca);
        ch_b   = 8'(cb);
        ch_c   = 8'(cc);
        gain_a = 8'(ga);
        gain_b = 8'(gb);
        gain_c = 8'(gc);
    endtask

    task automatic run_sample(input string tag, input int ca, input int cb, input int cc,
                              input int ga, input int gb, input int gc, input int expv);
        @(negedge clk);
        set_in(ca, cb, cc, ga, gb, gc);
        mute = 1'b0;
        wait_pulse(tag);
        wait_pulse(tag);
        check_val(tag, int'(out), expv);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_out", int'(out), 0);
        check_val("rst_sample", int'(sample), 0);
        #5 reset = 1'b0;

        // silence: first pulse lands DIV+4 edges after release, output stays 0
        wait_pulse("first");
        check_val("first_edge", edge_k, DIV + 4);
        check_val("silent_out", int'(out), 0);
        wait_pulse("second");
        check_val("second_edge", edge_k, 2 * DIV + 4);

        run_sample("ch_a_192", 192, 128, 128, 64, 64, 64, 16384);
        run_sample("sat_pos", 255, 255, 255, 255, 255, 255, 32767);
        run_sample("sat_neg", 0, 0, 0, 255, 255, 255, -32768);
        run_sample("zero_gain", 160, 96, 128, 0, 128, 64, -16384);
        run_sample("silent_gain", 128, 128, 128, 255, 17, 200, 0);

        // mute only across the capture edge
        @(negedge clk);
        set_in(200, 128, 90, 64, 64, 32);
        wait_phase(DIV - 1);
        mute = 1'b1;
        @(negedge clk);
        mute = 1'b0;
        wait_pulse("mute_cap");
        check_val("mute_cap", int'(out), 0);
        wait_pulse("mute_next");
        check_val("mute_next", int'(out), mix(200, 128, 90, 64, 64, 32, 1'b0));
        wait_phase(DIV / 2);
        mute = 1'b1;
        @(negedge clk);
        mute = 1'b0;
        wait_pulse("mute_between");
        check_val("mute_between", int'(out), mix(200, 128, 90, 64, 64, 32, 1'b0));

        // input change right after capture affects only the following sample
        wait_phase(0);
        ch_a = 8'd60;
        wait_pulse("late_old");
        check_val("late_old", int'(out), mix(200, 128, 90, 64, 64, 32, 1'b0));
        wait_pulse("late_new");
        check_val("late_new", int'(out), mix(60, 128, 90, 64, 64, 32, 1'b0));

        // reset while the sequencer is in MAC_B
        wait_phase(1);
        #5 reset = 1'b1;
        #1;
        check_val("midmac_out", int'(out), 0);
        check_val("midmac_sample", int'(sample), 0);
        repeat (3) @(negedge clk);
        #5 reset = 1'b0;
        wait_pulse("post_rst");
        check_val("post_rst_edge", edge_k, DIV + 4);
        check_val("post_rst_out", int'(out), mix(60, 128, 90, 64, 64, 32, 1'b0));

        // randomized inputs, checked every cycle by the reference
        for (int i = 0; i < 40 * DIV; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0: ch_a   = 8'($urandom_range(0, 255));
                1: ch_b   = 8'($urandom_range(0, 255));
                2: ch_c   = 8'($urandom_range(0, 255));
                3: gain_a = 8'($urandom_range(0, 255));
                4: gain_b = 8'($urandom_range(0, 255));
                5: gain_c = 8'($urandom_range(0, 255));
                6: mute   = ($urandom_range(0, 3) == 0);
                default: mute = 1'b0;
            endcase
        end
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
